// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder reused LSB-first over WIDTH clocks, closed by a carry flop.
// start/busy/done command handshake; Sum/Cout are registered and hold until the next done.

module full_adder (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic Sum,
  output logic Carry
);
  assign Sum   = A ^ B ^ C;
  assign Carry = (A & B) | (C & (A ^ B));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);
  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] partial;
  logic [WIDTH-1:0] partial_nxt;
  logic             carry_q;
  logic             fa_sum;
  logic             fa_carry;

  full_adder fa (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .C    (carry_q),
    .Sum  (fa_sum),
    .Carry(fa_carry)
  );

  // Sum bits enter at the MSB end so bit 0 lands in partial[0] after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_one
      assign partial_nxt = fa_sum;
    end else begin : g_multi
      assign partial_nxt = {fa_sum, partial[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST_BIT) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      carry_q <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      partial <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Sum     <= '0;
      Cout    <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_sh    <= A;
            b_sh    <= B;
            carry_q <= Cin;
            cnt     <= '0;
          end
        end
        RUN: begin
          partial <= partial_nxt;
          carry_q <= fa_carry;
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          cnt     <= cnt + CNT_W'(1);
          // Result is published on the same edge that processes the last bit,
          // so it is already valid while done is high.
          if (cnt == LAST_BIT) begin
            Sum  <= partial_nxt;
            Cout <= fa_carry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl at WIDTH 8, 1 and 16: queued A+B+Cin expectations
// are popped by per-instance monitors whenever done pulses.

module tb_serial_add_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  logic        start8, Cin8, busy8, done8, Cout8;
  logic [7:0]  A8, B8, Sum8;
  logic        start1, Cin1, busy1, done1, Cout1;
  logic [0:0]  A1, B1, Sum1;
  logic        start16, Cin16, busy16, done16, Cout16;
  logic [15:0] A16, B16, Sum16;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_a), .start(start8), .A(A8), .B(B8), .Cin(Cin8),
    .busy(busy8), .done(done8), .Sum(Sum8), .Cout(Cout8)
  );
  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_b), .start(start1), .A(A1), .B(B1), .Cin(Cin1),
    .busy(busy1), .done(done1), .Sum(Sum1), .Cout(Cout1)
  );
  serial_add_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_b), .start(start16), .A(A16), .B(B16), .Cin(Cin16),
    .busy(busy16), .done(done16), .Sum(Sum16), .Cout(Cout16)
  );

  logic [16:0] q8[$];
  logic [16:0] q1[$];
  logic [16:0] q16[$];
  logic [16:0] e8, e1, e16;
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (rst_a && done8) begin
      if (q8.size() == 0) check("w8_unexpected_done", 1, 0);
      else begin
        e8 = q8.pop_front();
        check("w8_result", {Cout8, Sum8}, e8);
      end
    end
  end
  always @(negedge clk) begin
    if (rst_b && done1) begin
      if (q1.size() == 0) check("w1_unexpected_done", 1, 0);
      else begin
        e1 = q1.pop_front();
        check("w1_result", {Cout1, Sum1}, e1);
      end
    end
  end
  always @(negedge clk) begin
    if (rst_b && done16) begin
      if (q16.size() == 0) check("w16_unexpected_done", 1, 0);
      else begin
        e16 = q16.pop_front();
        check("w16_result", {Cout16, Sum16}, e16);
      end
    end
  end

  function automatic int wid(int sel);
    case (sel)
      0:       return 8;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  function automatic logic get_busy(int sel);
    case (sel)
      0:       return busy8;
      1:       return busy1;
      default: return busy16;
    endcase
  endfunction

  function automatic logic get_done(int sel);
    case (sel)
      0:       return done8;
      1:       return done1;
      default: return done16;
    endcase
  endfunction

  task automatic drive(int sel, logic [15:0] a, logic [15:0] b, logic c, logic s);
    case (sel)
      0:       begin A8 = a[7:0]; B8 = b[7:0]; Cin8 = c; start8 = s; end
      1:       begin A1 = a[0];   B1 = b[0];   Cin1 = c; start1 = s; end
      default: begin A16 = a;     B16 = b;     Cin16 = c; start16 = s; end
    endcase
  endtask

  // Reference model: exact unsigned (WIDTH+1)-bit sum.
  task automatic push(int sel, logic [15:0] a, logic [15:0] b, logic c);
    logic [16:0] m;
    logic [16:0] e;
    m = (17'(1) << wid(sel)) - 17'(1);
    e = (17'(a) & m) + (17'(b) & m) + 17'(c);
    case (sel)
      0:       q8.push_back(e);
      1:       q1.push_back(e);
      default: q16.push_back(e);
    endcase
  endtask

  // One operation from IDLE: operands scrambled right after acceptance.
  task automatic run_op(int sel, logic [15:0] a, logic [15:0] b, logic c);
    int lat = 0;
    int nb = 0;
    bit seen = 0;
    push(sel, a, b, c);
    @(posedge clk); #1 drive(sel, a, b, c, 1'b1);
    @(posedge clk); #1 drive(sel, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    for (int i = 1; i <= 60 && !seen; i++) begin
      @(negedge clk);
      if (get_busy(sel)) nb++;
      if (get_done(sel)) begin seen = 1; lat = i; end
    end
    if (!seen) check($sformatf("w%0d_done_timeout", wid(sel)), 0, 1);
    else begin
      check($sformatf("w%0d_latency", wid(sel)), lat, wid(sel) + 1);
      check($sformatf("w%0d_busy_cycles", wid(sel)), nb, wid(sel));
    end
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, nd, d0;
    int dc[4];
    logic [2:0] v;
    rst_a = 1'b0; rst_b = 1'b0;
    drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0); drive(2, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("w8_reset_outputs",  {busy8, done8, Cout8, Sum8}, 0);
    check("w1_reset_outputs",  {busy1, done1, Cout1, Sum1}, 0);
    check("w16_reset_outputs", {busy16, done16, Cout16, Sum16}, 0);
    @(posedge clk); #1 rst_a = 1'b1; rst_b = 1'b1;

    // Directed cases at WIDTH 8
    run_op(0, 'h5A, 'h3C, 1'b0);
    run_op(0, 'hFF, 'h01, 1'b0);
    run_op(0, 'hFF, 'hFF, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("w8_hold_result", {busy8, done8, Cout8, Sum8}, {3'b001, 8'hFF});
    end

    // start and operand changes while RUN must be ignored
    push(0, 'h10, 'h20, 1'b0);
    @(posedge clk); #1 drive(0, 'h10, 'h20, 1'b0, 1'b1);
    @(posedge clk); #1 drive(0, 'h33, 'h44, 1'b1, 1'b0);
    nb = 0; nd = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (busy8) nb++;
      if (done8) nd++;
      if (i == 3) drive(0, 'hAA, 'h55, 1'b0, 1'b1);
      if (i == 5) drive(0, 'h77, 'h66, 1'b1, 1'b0);
    end
    check("w8_isolation_busy_cycles", nb, 8);
    check("w8_isolation_done_count", nd, 1);
    check("w8_isolation_sum", Sum8, 8'h30);

    // Reset during busy cycle 4 discards the operation
    push(0, 'h81, 'h81, 1'b0);
    @(posedge clk); #1 drive(0, 'h81, 'h81, 1'b0, 1'b1);
    @(posedge clk); #1 drive(0, 'h00, 'h00, 1'b0, 1'b0);
    nb = 0;
    for (int i = 0; i < 20 && nb < 4; i++) begin
      @(negedge clk);
      if (busy8) nb++;
    end
    check("w8_reached_busy4", nb, 4);
    rst_a = 1'b0;
    @(posedge clk); #1 rst_a = 1'b1; q8.delete();
    @(negedge clk);
    check("w8_after_reset", {busy8, done8, Cout8, Sum8}, 0);
    nb = 0; nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy8) nb++;
      if (done8) nd++;
    end
    check("w8_no_activity_after_reset", {nb, nd}, 0);
    run_op(0, 'h81, 'h81, 1'b0);

    // Level-held start restarts every WIDTH+2 cycles
    repeat (4) push(0, 'h01, 'h01, 1'b0);
    @(posedge clk); #1 drive(0, 'h01, 'h01, 1'b0, 1'b1);
    nd = 0;
    for (int i = 0; i < 80 && nd < 4; i++) begin
      @(negedge clk);
      if (done8) begin
        dc[nd] = cyc;
        nd++;
        if (nd == 4) start8 = 1'b0;
      end
    end
    check("w8_b2b_done_count", nd, 4);
    if (nd == 4)
      for (int k = 1; k < 4; k++) check("w8_b2b_period", dc[k] - dc[k-1], 10);
    start8 = 1'b0;
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy8 || done8) nb++;
    end
    check("w8_b2b_stopped", nb, 0);
    for (int k = 0; k < 6; k++) run_op(0, 16'($urandom), 16'($urandom), 1'($urandom));

    // WIDTH 1 exhaustive
    for (int k = 0; k < 8; k++) begin
      v = 3'(k);
      run_op(1, 16'(v[2]), 16'(v[1]), v[0]);
    end

    // WIDTH 16 corners and random
    run_op(2, 'hFFFF, 'hFFFF, 1'b1);
    run_op(2, 'h0000, 'h0000, 1'b0);
    run_op(2, 'hFFFF, 'h0000, 1'b1);
    for (int k = 0; k < 1000; k++) run_op(2, 16'($urandom), 16'($urandom), 1'($urandom));

    repeat (4) @(negedge clk);
    d0 = q8.size() + q1.size() + q16.size();
    check("scoreboard_drained", d0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
